// File: rtl/fft_butterfly.sv
// fft_butterfly: radix-2 DIT butterfly stage sitting behind the four twiddle
// multipliers. Operand A is delayed to line up with the multiplier products.
// T = B*W is then formed, and Y0 = A + T and Y1 = A - T are registered with
// saturation.
//
// Optional build macro: BUTTERFLY_SCALE_EN. When it is defined, each 19-bit sum
// is arithmetic-shifted right by 1 before saturation. This gives 1/2 scaling
// per stage. Latency is the same in both builds.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   in_valid        operand A (and the matching multiplier inputs) presented
//   a_re, a_im      operand A, Q1.16 two's complement
//   p_rr/p_ii/p_ri/p_ir  multiplier products Br*Wr, Bi*Wi, Br*Wi, Bi*Wr
//   clr_ovf         synchronous clear of ovf (a saturation event in the same cycle wins)
//   out_valid       y0/y1 valid this cycle
//   y0_re..y1_im    butterfly outputs, 17-bit two's complement
//   bfly_idx        index of the current output beat within the frame
//   frame_done      pulse on the last out_valid of a frame
//   ovf             sticky saturation flag
module fft_butterfly #(
    parameter int unsigned MUL_LAT        = 4,
    parameter int unsigned BFLY_PER_FRAME = 8,
    localparam int unsigned IDX_W         = $clog2(BFLY_PER_FRAME)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [16:0]      a_re,
    input  logic [16:0]      a_im,
    input  logic [16:0]      p_rr,
    input  logic [16:0]      p_ii,
    input  logic [16:0]      p_ri,
    input  logic [16:0]      p_ir,
    input  logic             clr_ovf,
    output logic             out_valid,
    output logic [16:0]      y0_re,
    output logic [16:0]      y0_im,
    output logic [16:0]      y1_re,
    output logic [16:0]      y1_im,
    output logic [IDX_W-1:0] bfly_idx,
    output logic             frame_done,
    output logic             ovf
);

    localparam int unsigned DW = 17;
    localparam int unsigned TW = 18;
    localparam int unsigned SW = 19;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BFLY_PER_FRAME - 1);

    // Widen A to the sum width.
    function automatic logic [SW-1:0] sx_a(input logic [DW-1:0] a);
        return {{2{a[DW-1]}}, a};
    endfunction

    // Widen T to the sum width.
    function automatic logic [SW-1:0] sx_t(input logic [TW-1:0] t);
        return {t[TW-1], t};
    endfunction

    // Optional 1/2 scaling. The shift truncates toward minus infinity.
    function automatic logic [SW-1:0] scale(input logic [SW-1:0] s);
`ifdef BUTTERFLY_SCALE_EN
        return {s[SW-1], s[SW-1:1]};
`else
        return s;
`endif
    endfunction

    // A value fits in 17 bits only when its top three bits agree.
    function automatic logic clips(input logic [SW-1:0] s);
        return !((s[SW-1:DW-1] == 3'b000) || (s[SW-1:DW-1] == 3'b111));
    endfunction

    // Saturate to [-65536, 65535].
    function automatic logic [DW-1:0] sat(input logic [SW-1:0] s);
        if (!clips(s)) begin
            return s[DW-1:0];
        end else if (s[SW-1]) begin
            return 17'h10000;
        end else begin
            return 17'h0FFFF;
        end
    endfunction

    // Alignment delay line for valid and operand A.
    logic [MUL_LAT-1:0] v_sr;
    logic [DW-1:0]      a_re_sr [MUL_LAT];
    logic [DW-1:0]      a_im_sr [MUL_LAT];
    logic               v_d;

    assign v_d = v_sr[MUL_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_sr <= '0;
            for (int i = 0; i < int'(MUL_LAT); i++) begin
                a_re_sr[i] <= '0;
                a_im_sr[i] <= '0;
            end
        end else begin
            v_sr[0]    <= in_valid;
            a_re_sr[0] <= a_re;
            a_im_sr[0] <= a_im;
            for (int i = 1; i < int'(MUL_LAT); i++) begin
                v_sr[i]    <= v_sr[i-1];
                a_re_sr[i] <= a_re_sr[i-1];
                a_im_sr[i] <= a_im_sr[i-1];
            end
        end
    end

    // Stage 1: complex product T from the four partial products.
    logic [TW-1:0] t_re_c, t_im_c;
    logic [TW-1:0] t_re, t_im;
    logic [DW-1:0] a1_re, a1_im;
    logic          v1;

    always_comb begin
        t_re_c = {p_rr[DW-1], p_rr} - {p_ii[DW-1], p_ii};
        t_im_c = {p_ri[DW-1], p_ri} + {p_ir[DW-1], p_ir};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1    <= 1'b0;
            t_re  <= '0;
            t_im  <= '0;
            a1_re <= '0;
            a1_im <= '0;
        end else begin
            v1 <= v_d;
            if (v_d) begin
                t_re  <= t_re_c;
                t_im  <= t_im_c;
                a1_re <= a_d_re();
                a1_im <= a_d_im();
            end
        end
    end

    function automatic logic [DW-1:0] a_d_re();
        return a_re_sr[MUL_LAT-1];
    endfunction

    function automatic logic [DW-1:0] a_d_im();
        return a_im_sr[MUL_LAT-1];
    endfunction

    // Stage 2: butterfly sums, optional scaling, and clip detection.
    logic [SW-1:0] s0_re, s0_im, s1_re, s1_im;
    logic          clip_any;

    always_comb begin
        s0_re    = scale(sx_a(a1_re) + sx_t(t_re));
        s0_im    = scale(sx_a(a1_im) + sx_t(t_im));
        s1_re    = scale(sx_a(a1_re) - sx_t(t_re));
        s1_im    = scale(sx_a(a1_im) - sx_t(t_im));
        clip_any = clips(s0_re) | clips(s0_im) | clips(s1_re) | clips(s1_im);
    end

    // Next frame index: it advances after each presented output beat.
    logic [IDX_W-1:0] idx_n;

    always_comb begin
        idx_n = bfly_idx;
        if (out_valid) begin
            idx_n = (bfly_idx == LAST_IDX) ? '0 : bfly_idx + IDX_W'(1);
        end
    end

    // Output registers: results hold between valid beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            y0_re      <= '0;
            y0_im      <= '0;
            y1_re      <= '0;
            y1_im      <= '0;
            bfly_idx   <= '0;
            frame_done <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            out_valid  <= v1;
            bfly_idx   <= idx_n;
            frame_done <= v1 && (idx_n == LAST_IDX);
            if (v1) begin
                y0_re <= sat(s0_re);
                y0_im <= sat(s0_im);
                y1_re <= sat(s1_re);
                y1_im <= sat(s1_im);
            end
            if (v1 && clip_any) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_butterfly.sv
// Scoreboard bench for fft_butterfly. The driver issues beats and pushes the
// expected butterfly results computed with plain integer arithmetic. A monitor
// pops and compares each output on the falling edge.
module tb_fft_butterfly;

    localparam int MUL_LAT = 4;
    localparam int BPF     = 8;
    localparam int IDX_W   = $clog2(BPF);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [16:0]      a_re = '0, a_im = '0;
    logic [16:0]      p_rr = '0, p_ii = '0, p_ri = '0, p_ir = '0;
    logic             clr_ovf = 1'b0;
    logic             out_valid;
    logic [16:0]      y0_re, y0_im, y1_re, y1_im;
    logic [IDX_W-1:0] bfly_idx;
    logic             frame_done;
    logic             ovf;

    fft_butterfly #(.MUL_LAT(MUL_LAT), .BFLY_PER_FRAME(BPF)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .a_re(a_re), .a_im(a_im),
        .p_rr(p_rr), .p_ii(p_ii), .p_ri(p_ri), .p_ir(p_ir),
        .clr_ovf(clr_ovf), .out_valid(out_valid),
        .y0_re(y0_re), .y0_im(y0_im), .y1_re(y1_re), .y1_im(y1_im),
        .bfly_idx(bfly_idx), .frame_done(frame_done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int y0r, y0i, y1r, y1i;
        int idx;
        bit fd;
        bit clip;
    } exp_t;

    typedef struct {
        bit v;
        int rr, ii, ri, ir;
    } prod_t;

    exp_t  sb[$];
    prod_t pend[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    int    model_idx = 0;
    bit    clr_at[int];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rnd17();
        return int'($urandom_range(131071, 0)) - 65536;
    endfunction

    // Reference lane: exact sum, optional floor-halving, then clamp to 17 bits.
    function automatic int lane(input int a, input int t, input bit sub, inout bit clip);
        int s;
        s = sub ? a - t : a + t;
`ifdef BUTTERFLY_SCALE_EN
        s = s >>> 1;
`endif
        if (s > 65535) begin
            clip = 1'b1;
            return 65535;
        end
        if (s < -65536) begin
            clip = 1'b1;
            return -65536;
        end
        return s;
    endfunction

    // One clock of stimulus. Products for a beat go out MUL_LAT steps after the beat.
    task automatic step(input bit v, input int ar, input int ai,
                        input int rr, input int ii, input int ri, input int ir,
                        input bit c = 1'b0);
        prod_t e, cur;
        exp_t  x;
        int    tr, ti;
        in_valid = v;
        a_re     = 17'(ar);
        a_im     = 17'(ai);
        clr_ovf  = c;
        if (c) clr_at[cyc + 1] = 1'b1;
        e.v = v; e.rr = rr; e.ii = ii; e.ri = ri; e.ir = ir;
        pend.push_back(e);
        cur.v = 1'b0; cur.rr = 0; cur.ii = 0; cur.ri = 0; cur.ir = 0;
        if (pend.size() > MUL_LAT) cur = pend.pop_front();
        if (cur.v) begin
            p_rr = 17'(cur.rr); p_ii = 17'(cur.ii);
            p_ri = 17'(cur.ri); p_ir = 17'(cur.ir);
        end else begin
            p_rr = 17'($urandom); p_ii = 17'($urandom);
            p_ri = 17'($urandom); p_ir = 17'($urandom);
        end
        if (v) begin
            tr     = rr - ii;
            ti     = ri + ir;
            x.clip = 1'b0;
            x.y0r  = lane(ar, tr, 1'b0, x.clip);
            x.y0i  = lane(ai, ti, 1'b0, x.clip);
            x.y1r  = lane(ar, tr, 1'b1, x.clip);
            x.y1i  = lane(ai, ti, 1'b1, x.clip);
            x.cyc  = cyc + MUL_LAT + 2;
            x.idx  = model_idx;
            x.fd   = (model_idx == BPF - 1);
            model_idx = (model_idx + 1) % BPF;
            sb.push_back(x);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares outputs, hold behaviour, and the sticky overflow flag.
    bit prev_rst  = 1'b1;
    bit model_ovf = 1'b0;
    int l0r = 0, l0i = 0, l1r = 0, l1i = 0;

    always @(negedge clk) begin
        exp_t x;
        bit   popped_clip;
        int   g0r, g0i, g1r, g1i;
        g0r = int'($signed(y0_re)); g0i = int'($signed(y0_im));
        g1r = int'($signed(y1_re)); g1i = int'($signed(y1_im));
        popped_clip = 1'b0;
        if (rst) begin
            sb.delete();
            model_ovf = 1'b0;
            l0r = 0; l0i = 0; l1r = 0; l1i = 0;
            prev_rst = 1'b1;
        end else begin
            if (prev_rst) begin
                tests++;
                if (out_valid || frame_done || ovf || bfly_idx != '0 ||
                    g0r != 0 || g0i != 0 || g1r != 0 || g1i != 0) begin
                    fails++;
                    $display("FAIL reset_state: ov=%0d fd=%0d ovf=%0d idx=%0d y=(%0d,%0d,%0d,%0d), required all 0",
                             out_valid, frame_done, ovf, bfly_idx, g0r, g0i, g1r, g1i);
                end
            end
            prev_rst = 1'b0;
            if (out_valid) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL spurious_out: out_valid at cyc %0d, required no beat", cyc);
                end else begin
                    x = sb.pop_front();
                    popped_clip = x.clip;
                    l0r = x.y0r; l0i = x.y0i; l1r = x.y1r; l1i = x.y1i;
                    if (x.cyc != cyc || g0r != x.y0r || g0i != x.y0i || g1r != x.y1r ||
                        g1i != x.y1i || int'(bfly_idx) != x.idx || frame_done != x.fd) begin
                        fails++;
                        $display("FAIL beat: cyc=%0d y0=(%0d,%0d) y1=(%0d,%0d) idx=%0d fd=%0d, required cyc=%0d y0=(%0d,%0d) y1=(%0d,%0d) idx=%0d fd=%0d",
                                 cyc, g0r, g0i, g1r, g1i, bfly_idx, frame_done,
                                 x.cyc, x.y0r, x.y0i, x.y1r, x.y1i, x.idx, x.fd);
                    end
                end
            end else begin
                if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    tests++;
                    fails++;
                    x = sb.pop_front();
                    $display("FAIL missing_out: no out_valid at cyc %0d, required beat at cyc %0d", cyc, x.cyc);
                end
                tests++;
                if (frame_done || g0r != l0r || g0i != l0i || g1r != l1r || g1i != l1i) begin
                    fails++;
                    $display("FAIL hold: fd=%0d y=(%0d,%0d,%0d,%0d), required fd=0 y=(%0d,%0d,%0d,%0d)",
                             frame_done, g0r, g0i, g1r, g1i, l0r, l0i, l1r, l1i);
                end
            end
            if (popped_clip) model_ovf = 1'b1;
            else if (clr_at.exists(cyc)) model_ovf = 1'b0;
            tests++;
            if (ovf != model_ovf) begin
                fails++;
                $display("FAIL ovf: cyc=%0d got %0d, required %0d", cyc, ovf, model_ovf);
            end
        end
    end

    initial begin
        bit v;
        @(negedge clk);
        idle(2);
        #2 rst = 1'b0;

        // Basic beat, and the scale-build values.
        step(1'b1, 1000, 0, 500, 0, 0, 0);
        idle(7);
        step(1'b1, 1000, -3, 500, 0, 0, 0);
        idle(7);

        // Saturation, overflow held, then cleared.
        step(1'b1, 60000, 0, 30000, -10000, 0, 0);
        idle(10);
        step(1'b0, 0, 0, 0, 0, 0, 0, 1'b1);
        idle(3);

        // Two back-to-back frames.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, rnd17(), rnd17(), rnd17(), rnd17(), rnd17(), rnd17());
        end
        idle(8);

        // Bubble pattern 1,0,1,1,0,1 with distinct operands.
        for (int i = 0; i < 6; i++) begin
            v = (i != 1) && (i != 4);
            step(v, 100 * (i + 1), -50 * (i + 1), 7 * i, -3 * i, 11 * i, 5 * i);
        end
        idle(8);

        // Reset with beats in flight.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1234 + i, 4321 - i, 300, 200, 100, 50);
        end
        idle(2);
        #2 rst = 1'b1;
        @(negedge clk);
        model_idx = 0;
        #2 rst = 1'b0;
        idle(12);

        // Random traffic with bubbles and occasional clears.
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(9, 0) < 7, rnd17(), rnd17(), rnd17(), rnd17(),
                 rnd17(), rnd17(), $urandom_range(15, 0) == 0);
        end
        idle(12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fft_butterfly.md
# fft_butterfly

Radix-2 decimation-in-time butterfly stage for the FFT datapath, placed directly downstream of the four `multi17` twiddle multipliers that form the complex product B·W.
- Each input beat presents operand A; the block delays A and its valid flag to line up with the fixed multiplier latency.
- It forms T = B·W from the four real partial products and registers Y0 = A + T and Y1 = A − T with saturation.
- It counts butterflies per frame and reports a sticky overflow flag to the control FSM.

## Interface
- `MUL_LAT`, 4: latency in cycles of the `multi17` instances feeding `p_*` (input sample to product valid).
- `BFLY_PER_FRAME`, 8: butterflies per stage frame (N/2); must be ≥2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `in_valid`  in  1  A (and the matching multiplier inputs) presented this cycle.
- `a_re`, `a_im`  in  17 each  operand A, two's complement, Q1.16 fraction.
- `p_rr`, `p_ii`, `p_ri`, `p_ir`  in  17 each  multiplier outputs Br·Wr, Bi·Wi, Br·Wi, Bi·Wr; two's complement.
- `clr_ovf`  in  1  synchronous clear of `ovf`.
- `out_valid`  out  1  Y0/Y1 valid this cycle.
- `y0_re`, `y0_im`, `y1_re`, `y1_im`  out  17 each  butterfly outputs, two's complement.
- `bfly_idx`  out  log2(BFLY_PER_FRAME)  index of the current output beat within the frame.
- `frame_done`  out  1  one-cycle pulse coincident with the last `out_valid` of a frame.
- `ovf`  out  1  sticky; set when any output lane saturated.

## Operation
- **Alignment.** `in_valid`, `a_re` and `a_im` pass through a `MUL_LAT`-deep shift register. Its tap `v_d` marks the cycle in which the `p_*` inputs are valid. `p_*` are ignored whenever `v_d` = 0.
- **Stage 1, registered when `v_d` = 1.**
  - t_re = p_rr − p_ii, 18-bit sign-extended.
  - t_im = p_ri + p_ir, 18-bit sign-extended.
  - A is copied alongside T; valid moves to `v1`.
- **Stage 2, registered when `v1` = 1.**
  - Each sum s = a ± t is computed at 19 bits.
  - Each s is then scaled (see Configuration) and saturated to the 17-bit range [−65536, 65535].
  - If any of the four lanes clips, `ovf` is set.
- **Output hold.** Outputs hold their value when there is no valid beat. `out_valid` is the registered copy of `v1`.
- **Frame counter.**
  - `bfly_idx` advances on each `out_valid` beat and wraps from BFLY_PER_FRAME−1 to 0.
  - `frame_done` = `out_valid` && (`bfly_idx` == BFLY_PER_FRAME−1).
- **`ovf` clear.** `clr_ovf` and a saturation event in the same cycle: set wins.
- **Reset value.** All outputs are 0, `bfly_idx` = 0, and the delay line and all valid stages are cleared.
  - Beats in flight at reset are discarded and never produce `out_valid`.
  - Products arriving after reset for pre-reset beats are ignored, because `v_d` = 0.

## Timing
- **Latency.** `in_valid` at cycle n gives `out_valid` at cycle n + MUL_LAT + 2, which is n+6 at the default.
- **Throughput.** One butterfly per cycle, with no back-pressure. Bubbles in `in_valid` appear unchanged at `out_valid`.
- **Frame pulse.** `frame_done` and `bfly_idx` are registered and change in the same cycle as `out_valid`.
- **First output after reset.** With `in_valid` first high in cycle c after `rst` deasserts, the earliest `out_valid` is c + MUL_LAT + 2.
- **Wrap.** `bfly_idx` returns to 0 on the beat after `frame_done`. No idle cycle is needed between frames.

## Configuration
- `BUTTERFLY_SCALE_EN` defined:
  - The 19-bit sum is arithmetic-shifted right by 1 before saturation (truncation toward −∞), giving per-stage ½ scaling against word growth.
  - Saturation and `ovf` still apply to the shifted value.
- `BUTTERFLY_SCALE_EN` undefined:
  - The sum is saturated directly with no shift.
- Latency is identical in both builds.

## Test plan
- **Basic beat (no scale).**
  - Stimulus: `in_valid` pulse with a = (1000, 0); four cycles later p_rr = 500, others 0.
  - Required: one `out_valid` at +6, y0 = (1500, 0), y1 = (500, 0), `ovf` = 0.
- **Saturation.**
  - Stimulus: a_re = 60000, p_rr = 30000, p_ii = −10000, so t_re = 40000.
  - Required: y0_re = 65535, y1_re = 20000, `ovf` = 1 and held.
  - Then `clr_ovf` pulse → `ovf` = 0 next cycle.
- **Frame wrap.**
  - Stimulus: 8 back-to-back beats, then 8 more.
  - Required: `bfly_idx` runs 0..7 twice, and `frame_done` pulses exactly on the 8th and 16th `out_valid`.
- **Bubbles.**
  - Stimulus: `in_valid` pattern 1,0,1,1,0,1 with distinct A values; `p_*` driven with garbage when not aligned.
  - Required: `out_valid` pattern is identical, shifted by 6 cycles, and results are unaffected by the garbage.
- **Reset mid-flight.**
  - Stimulus: 3 beats issued, `rst` pulsed 2 cycles later.
  - Required: no `out_valid` ever appears for those beats, all outputs are 0, `bfly_idx` = 0.
- **Scale build (`BUTTERFLY_SCALE_EN`).**
  - Stimulus: a = (1000, −3), p_rr = 500, others 0.
  - Required: y0 = (750, −2), y1 = (250, −2).
